vc_test_delay_arb: RTL and testbench



---
 rtl/vc_test_delay_arb_pkg.sv | 26 ++
 rtl/vc_lfsr32.sv | 36 +++
 rtl/vc_test_delay_arb.sv | 129 ++++++++++++
 tb/tb_vc_test_delay_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_delay_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : vc_test_delay_arb_pkg
// Brief    : Shared types and constants for the delayed round-robin arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package vc_test_delay_arb_pkg;

  // Arbiter FSM: wait for a request, hold off a random time, then offer it
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Galois feedback mask for the 32-bit hold-off LFSR
  localparam logic [31:0] c_lfsr_poly    = 32'h8020_0003;

  // Default LFSR reset value; must be nonzero or the LFSR locks up
  localparam logic [31:0] c_default_seed = 32'h0000_0001;

endpackage

`default_nettype wire

// File: rtl/vc_lfsr32.sv
//------------------------------------------------------------------------------
// Module   : vc_lfsr32
// Brief    : 32-bit right-shifting Galois LFSR, reloaded with seed on reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module vc_lfsr32
  import vc_test_delay_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] r_q;
  logic [31:0] w_next;

  // Shift right; when a one falls out, fold the polynomial back in
  always_comb begin
    w_next = r_q[0] ? ((r_q >> 1) ^ c_lfsr_poly) : (r_q >> 1);
  end

  // Advance every cycle out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= seed;
    else          r_q <= w_next;
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/vc_test_delay_arb.sv
//------------------------------------------------------------------------------
// Module   : vc_test_delay_arb
// Brief    : Round-robin arbiter that inserts a random hold-off before
//            offering each granted message on a shared valid/ready output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module vc_test_delay_arb
  import vc_test_delay_arb_pkg::*;
#(
  parameter int          p_msg_nbits = 32,
  parameter int          p_num_reqs  = 4,
  parameter logic [31:0] p_seed      = c_default_seed
)(
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [31:0]                     max_delay,
  input  logic [p_num_reqs-1:0]           in_val,
  output logic [p_num_reqs-1:0]           in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic [p_msg_nbits-1:0]          out_msg,
  output logic [$clog2(p_num_reqs)-1:0]   out_grant,
  output logic [31:0]                     xfer_count
);

  localparam int c_idx_nbits = $clog2(p_num_reqs);

  state_t                 r_state;
  logic [c_idx_nbits-1:0] r_ptr;
  logic [c_idx_nbits-1:0] r_grant;
  logic [31:0]            r_cnt;
  logic [31:0]            r_xfer_count;

  logic [31:0]            w_lfsr;
  logic [c_idx_nbits-1:0] w_pick;
  logic [31:0]            w_holdoff;
  logic                   w_grant_val;
  logic                   w_send;

  // First set request at or above ptr, wrapping; walking downward lets the
  // nearest one overwrite the farther ones
  function automatic logic [c_idx_nbits-1:0] rr_pick(
    input logic [p_num_reqs-1:0]  val,
    input logic [c_idx_nbits-1:0] ptr
  );
    logic [c_idx_nbits-1:0] idx;
    rr_pick = ptr;
    for (int i = p_num_reqs - 1; i >= 0; i--) begin
      idx = ptr + c_idx_nbits'(i);
      if (val[idx]) rr_pick = idx;
    end
  endfunction

  vc_lfsr32 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (p_seed),
    .q       (w_lfsr)
  );

  // Winner and hold-off for a pick made this cycle
  always_comb begin
    w_pick    = rr_pick(in_val, r_ptr);
    w_holdoff = (max_delay == 32'd0) ? 32'd0 : (w_lfsr % max_delay);
  end

  // Output handshake is only live in SEND; the granted requester sees out_rdy
  always_comb begin
    w_grant_val = in_val[r_grant];
    w_send      = (r_state == SEND);
    out_val     = w_send & w_grant_val;
    out_msg     = out_val ? in_msg[r_grant*p_msg_nbits +: p_msg_nbits] : '0;
    out_grant   = out_val ? r_grant : '0;
    in_rdy      = '0;
    if (w_send) in_rdy[r_grant] = out_rdy;
  end

  // Arbiter FSM: pick, count down the hold-off, offer, advance the pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_grant      <= '0;
      r_cnt        <= '0;
      r_xfer_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|in_val) begin
            r_grant <= w_pick;
            r_cnt   <= w_holdoff;
            r_state <= (w_holdoff == 32'd0) ? SEND : DELAY;
          end
        end
        DELAY: begin
          if (!w_grant_val) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
            if (r_cnt == 32'd1) r_state <= SEND;
          end
        end
        SEND: begin
          if (!w_grant_val) begin
            r_state <= IDLE;
          end else if (out_rdy) begin
            r_state      <= IDLE;
            r_ptr        <= r_grant + 1'b1;
            r_xfer_count <= r_xfer_count + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign xfer_count = r_xfer_count;

  // Control inputs and handshake outputs must be known once out of reset
  a_no_x : assert property (@(posedge clk) disable iff (!reset_n)
    !$isunknown({max_delay, in_val, out_rdy, out_val, in_rdy}));

endmodule

`default_nettype wire

// File: tb/tb_vc_test_delay_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_vc_test_delay_arb
// Brief    : Self-checking bench for vc_test_delay_arb with a transaction-level
//            reference model and a few literal scenarios.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vc_test_delay_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [31:0]    max_delay = '0;
  logic [N-1:0]   in_val = '0;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_msg = '0;
  logic           out_val;
  logic           out_rdy = 1'b0;
  logic [W-1:0]   out_msg;
  logic [1:0]     out_grant;
  logic [31:0]    xfer_count;

  always #5 clk = ~clk;

  vc_test_delay_arb #(.p_msg_nbits(W), .p_num_reqs(N), .p_seed(32'h1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .max_delay  (max_delay),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_msg     (in_msg),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .out_grant  (out_grant),
    .xfer_count (xfer_count)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int glog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A request is either absent (m_busy=0) or pending for requester m_g with
  // m_wait cycles of hold-off left; with no hold-off left it is offered.
  logic [31:0] m_lfsr;
  logic [31:0] m_wait;
  logic [31:0] m_count;
  int          m_ptr, m_g;
  bit          m_busy;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr = 32'h1; m_wait = '0; m_count = '0;
    m_ptr = 0; m_g = 0; m_busy = 0;
  endtask

  task automatic model_step();
    logic [31:0] cur;
    bit found;
    cur    = m_lfsr;
    m_lfsr = lfsr_next(cur);
    if (!m_busy) begin
      if (in_val != '0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && in_val[(m_ptr + k) % N]) begin
            m_g   = (m_ptr + k) % N;
            found = 1;
          end
        end
        m_wait = (max_delay == 0) ? 32'd0 : (cur % max_delay);
        m_busy = 1;
      end
    end else if (!in_val[m_g]) begin
      m_busy = 0;
    end else if (m_wait != 0) begin
      m_wait = m_wait - 1;
    end else if (out_rdy) begin
      m_busy  = 0;
      m_ptr   = (m_g + 1) % N;
      m_count = m_count + 1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit           offer;
    bit           ev;
    logic [N-1:0] er;
    offer = m_busy && (m_wait == 0);
    ev    = offer && in_val[m_g];
    er    = offer ? (N'(out_rdy) << m_g) : '0;
    check("out_val",    64'(out_val),    64'(ev));
    check("out_msg",    64'(out_msg),    ev ? 64'(in_msg[m_g*W +: W]) : 64'd0);
    check("out_grant",  64'(out_grant),  ev ? 64'(m_g) : 64'd0);
    check("in_rdy",     64'(in_rdy),     64'(er));
    check("xfer_count", 64'(xfer_count), 64'(m_count));
    if (out_val && out_rdy) glog.push_back(int'(out_grant));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_val    = '0;
    out_rdy   = 1'b0;
    max_delay = '0;
    tick();
    check("rst_out_val", 64'(out_val),    64'd0);
    check("rst_in_rdy",  64'(in_rdy),     64'd0);
    check("rst_xfer",    64'(xfer_count), 64'd0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) in_msg[i*W +: W] = 32'hA5A5_0000 + 32'(i);

    // Four requesters held with zero hold-off: 0,1,2,3,0 every two cycles
    do_reset();
    glog.delete();
    out_rdy = 1'b1;
    in_val  = 4'b1111;
    tick();
    check("rr_latency_val", 64'(out_val), 64'd1);
    repeat (7) tick();
    check("rr_count8", 64'(xfer_count), 64'd4);
    check("rr_nlog", 64'(glog.size()), 64'd4);
    for (int k = 0; k < 4; k++) check("rr_grant", 64'(glog[k]), 64'(k));
    repeat (2) tick();
    check("rr_wrap_grant", 64'(glog[4]), 64'd0);
    in_val = '0;

    // Backpressure: requester 2 offered while out_rdy is low
    do_reset();
    in_val = 4'b0100;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_val",   64'(out_val),   64'd1);
      check("bp_grant", 64'(out_grant), 64'd2);
      check("bp_rdy",   64'(in_rdy),    64'd0);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    check("bp_rdy_rise", 64'(in_rdy), 64'b0100);
    tick();
    check("bp_xfer", 64'(xfer_count), 64'd1);
    in_val = '0;

    // Drop during DELAY: seed 1 gives hold-off 1 % 8 = 1 on the first pick
    do_reset();
    max_delay = 32'd8;
    out_rdy   = 1'b1;
    in_val    = 4'b0010;
    tick();
    check("drop_in_delay", 64'(out_val), 64'd0);
    in_val = '0;
    tick();
    tick();
    check("drop_xfer", 64'(xfer_count), 64'd0);
    max_delay = '0;
    in_val    = 4'b1111;
    tick();
    check("drop_ptr_grant", 64'(out_grant), 64'd0);
    check("drop_ptr_val",   64'(out_val),   64'd1);
    tick();
    in_val = '0;

    // Asynchronous reset mid-SEND, then LFSR reload seen through hold-off
    do_reset();
    in_val  = 4'b0001;
    out_rdy = 1'b1;
    tick();
    tick();
    check("ar_xfer_pre", 64'(xfer_count), 64'd1);
    out_rdy = 1'b0;
    tick();
    check("ar_send_val", 64'(out_val), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_out_val",   64'(out_val),    64'd0);
    check("ar_in_rdy",    64'(in_rdy),     64'd0);
    check("ar_out_grant", 64'(out_grant),  64'd0);
    check("ar_out_msg",   64'(out_msg),    64'd0);
    check("ar_xfer",      64'(xfer_count), 64'd0);
    tick();
    reset_n   = 1'b1;
    max_delay = 32'd8;
    in_val    = 4'b0010;
    out_rdy   = 1'b1;
    tick();
    check("seed_delay_val", 64'(out_val), 64'd0);
    tick();
    check("seed_send_val",   64'(out_val),   64'd1);
    check("seed_send_grant", 64'(out_grant), 64'd1);
    check("seed_send_msg",   64'(out_msg),   64'hA5A5_0001);
    tick();
    check("seed_xfer", 64'(xfer_count), 64'd1);
    in_val = '0;

    // Wrap: pointer 0 picks 3, then pointer wraps back to 0 and picks 0
    do_reset();
    out_rdy = 1'b1;
    in_val  = 4'b1000;
    tick();
    check("wrap_grant3", 64'(out_grant), 64'd3);
    tick();
    in_val = 4'b0001;
    tick();
    check("wrap_grant0", 64'(out_grant), 64'd0);
    tick();
    check("wrap_xfer", 64'(xfer_count), 64'd2);
    in_val = '0;

    // Randomized traffic checked cycle-by-cycle against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) in_val = N'($urandom);
      out_rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 4))
          0:       max_delay = 32'd0;
          1:       max_delay = 32'd1;
          2:       max_delay = 32'd3;
          3:       max_delay = 32'd8;
          default: max_delay = 32'($urandom_range(2, 40));
        endcase
      end
      for (int i = 0; i < N; i++) in_msg[i*W +: W] = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
